bcs_compare_scheduler: RTL

Time-shares one `BCSBasedComparator` instance among `NREQ` requesters. Round-robin arbitration grants one operand pair at a time, drives it onto the comparator, waits a fixed settle interval, then returns EQ/GT tagged with the requester ID over a valid/ready response channel. It sits between the operand producers and the combinational comparator and owns all comparator timing.

---
 rtl/bcs_sched_pkg.sv | 18 +
 rtl/bcs_rr_arbiter.sv | 30 +++
 rtl/bcs_compare_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bcs_sched_pkg.sv
// Shared types and constants for the BCS comparator scheduler.
// The optional statistics counters are enabled by defining BCS_SCHED_STATS_EN.
package bcs_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } bcs_sched_state_t;

    localparam int BCS_STAT_W = 16;

    // Saturating increment used by the statistics counters.
    function automatic logic [BCS_STAT_W-1:0] bcs_sat_inc(input logic [BCS_STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bcs_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, with wrap.
module bcs_rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                w_found     = 1'b1;
                gnt[w_idx]  = 1'b1;
                gnt_id      = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/bcs_compare_scheduler.sv
// Time-shares one external comparator among NREQ requesters with round-robin grants.
// Define BCS_SCHED_STATS_EN to add saturating handshake/GT statistics outputs.
module bcs_compare_scheduler
    import bcs_sched_pkg::*;
#(
    parameter  int WIDTH         = 8,
    parameter  int NREQ          = 4,
    parameter  int SETTLE_CYCLES = 2,
    localparam int IDW           = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
    output logic [NREQ-1:0]             req_ready,
    output logic [WIDTH-1:0]            cmp_a,
    output logic [WIDTH-1:0]            cmp_b,
    input  logic                        cmp_eq,
    input  logic                        cmp_gt,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic                        rsp_eq,
    output logic                        rsp_gt,
    output logic                        busy
`ifdef BCS_SCHED_STATS_EN
    ,
    output logic [BCS_STAT_W-1:0]       stat_done,
    output logic [BCS_STAT_W-1:0]       stat_gt
`endif
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    bcs_sched_state_t   r_state;
    bcs_sched_state_t   w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]   r_settle_cnt;
    logic [WIDTH-1:0]   r_cmp_a;
    logic [WIDTH-1:0]   r_cmp_b;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic               r_rsp_eq;
    logic               r_rsp_gt;
    logic [NREQ-1:0]    w_gnt;
    logic [IDW-1:0]     w_gnt_id;
    logic               w_xfer;
    logic               w_hs;

    bcs_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .ptr    (r_rr_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_xfer      = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!reset) req_ready = w_gnt;
                if (|w_gnt) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: if (r_settle_cnt == '0) w_state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_settle_cnt <= '0;
            r_cmp_a      <= '0;
            r_cmp_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_eq     <= 1'b0;
            r_rsp_gt     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_cmp_a      <= req_a[w_gnt_id];
                r_cmp_b      <= req_b[w_gnt_id];
                r_rsp_id     <= w_gnt_id;
                r_settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
            end
            if (r_state == SETTLE) begin
                if (r_settle_cnt == '0) begin
                    r_rsp_eq    <= cmp_eq;
                    r_rsp_gt    <= cmp_gt;
                    r_rsp_valid <= 1'b1;
                end else begin
                    r_settle_cnt <= r_settle_cnt - 1'b1;
                end
            end
            // Pointer moves past the served requester only once its result is taken.
            if (w_hs) begin
                r_rsp_valid <= 1'b0;
                r_rr_ptr    <= (r_rsp_id == IDW'(NREQ - 1)) ? '0 : r_rsp_id + 1'b1;
            end
        end
    end

`ifdef BCS_SCHED_STATS_EN
    logic [BCS_STAT_W-1:0] r_stat_done;
    logic [BCS_STAT_W-1:0] r_stat_gt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_done <= '0;
            r_stat_gt   <= '0;
        end else if (w_hs) begin
            r_stat_done <= bcs_sat_inc(r_stat_done);
            if (r_rsp_gt) r_stat_gt <= bcs_sat_inc(r_stat_gt);
        end
    end

    assign stat_done = r_stat_done;
    assign stat_gt   = r_stat_gt;
`endif

    assign cmp_a     = r_cmp_a;
    assign cmp_b     = r_cmp_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_eq    = r_rsp_eq;
    assign rsp_gt    = r_rsp_gt;
    assign busy      = (r_state != IDLE);

endmodule
